// File: rtl/ula_pkg.sv
// Shared types and instruction field layout for the ALU instruction sequencer.
package ula_pkg;

    localparam int W      = 8;
    localparam int NREG   = 4;
    localparam int RA_W   = 2;
    localparam int INSTR_W = 16;

    // Instruction field positions; imm deliberately overlaps rb
    localparam int OP_MSB  = 15;
    localparam int OP_LSB  = 13;
    localparam int RD_MSB  = 12;
    localparam int RD_LSB  = 11;
    localparam int RA_MSB  = 10;
    localparam int RA_LSB  = 9;
    localparam int RB_MSB  = 8;
    localparam int RB_LSB  = 7;
    localparam int IMM_MSB = 7;
    localparam int IMM_LSB = 0;

    typedef enum logic [2:0] {
        OP_INC0 = 3'b000,
        OP_INC1 = 3'b001,
        OP_OUT  = 3'b010,
        OP_LDI  = 3'b011,
        OP_ADD  = 3'b100,
        OP_SUB  = 3'b101,
        OP_AND  = 3'b110,
        OP_OR   = 3'b111
    } op_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_OUT  = 2'd2
    } estado_t;

endpackage

// File: rtl/ula_banco_regs.sv
// Register file: two combinational read ports, one synchronous write port,
// asynchronous clear.
module ula_banco_regs
    import ula_pkg::*;
#(
    parameter int DW = W,
    parameter int NR = NREG,
    parameter int AW = RA_W
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [AW-1:0] ra_addr_i,
    input  logic [AW-1:0] rb_addr_i,
    output logic [DW-1:0] ra_data_o,
    output logic [DW-1:0] rb_data_o,
    input  logic          we_i,
    input  logic [AW-1:0] wa_i,
    input  logic [DW-1:0] wd_i
);

    logic [NR-1:0][DW-1:0] regs_q;

    for (genvar g = 0; g < NR; g++) begin : g_reg
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
                regs_q[g] <= '0;
            else if (we_i && (wa_i == AW'(g)))
                regs_q[g] <= wd_i;
        end
    end

    assign ra_data_o = regs_q[ra_addr_i];
    assign rb_data_o = regs_q[rb_addr_i];

endmodule

// File: rtl/ula_sequenciador.sv
// Instruction sequencer feeding an external combinational 8-bit ALU; writes the
// ALU result back to a 4x8 register file, plus load-immediate and register-out ops.
module ula_sequenciador
    import ula_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               instr_valid,
    output logic               instr_ready,
    input  logic [INSTR_W-1:0] instr_data,
    output logic [2:0]         ula_ctrl,
    output logic [W-1:0]       ula_src0,
    output logic [W-1:0]       ula_src1,
    input  logic [W-1:0]       ula_result,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic [W-1:0]       dout_data,
    output logic               zero,
    output logic               busy
);

    estado_t          state_q, state_d;
    op_t              op_q, op_d;
    logic [RA_W-1:0]  rd_q, rd_d;
    logic [W-1:0]     imm_q, imm_d;
    op_t              ctrl_q, ctrl_d;
    logic [W-1:0]     src0_q, src0_d;
    logic [W-1:0]     src1_q, src1_d;
    logic [W-1:0]     dout_q, dout_d;
    logic             zero_q, zero_d;

    op_t              op_in;
    logic [RA_W-1:0]  ra_in, rb_in;
    logic [W-1:0]     ra_data, rb_data;
    logic             we;
    logic [W-1:0]     wd;

    assign op_in = op_t'(instr_data[OP_MSB:OP_LSB]);
    assign ra_in = instr_data[RA_MSB:RA_LSB];
    assign rb_in = instr_data[RB_MSB:RB_LSB];

    ula_banco_regs #(.DW(W), .NR(NREG), .AW(RA_W)) u_banco (
        .clk       (clk),
        .rst_n     (rst_n),
        .ra_addr_i (ra_in),
        .rb_addr_i (rb_in),
        .ra_data_o (ra_data),
        .rb_data_o (rb_data),
        .we_i      (we),
        .wa_i      (rd_q),
        .wd_i      (wd)
    );

    // LDI bypasses the ALU; everything else takes the ALU's answer
    assign wd = (op_q == OP_LDI) ? imm_q : ula_result;

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        rd_d    = rd_q;
        imm_d   = imm_q;
        ctrl_d  = ctrl_q;
        src0_d  = src0_q;
        src1_d  = src1_q;
        dout_d  = dout_q;
        zero_d  = zero_q;
        we      = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (instr_valid) begin
                    op_d  = op_in;
                    rd_d  = instr_data[RD_MSB:RD_LSB];
                    imm_d = instr_data[IMM_MSB:IMM_LSB];
                    case (op_in)
                        OP_OUT: begin
                            dout_d  = ra_data;
                            state_d = ST_OUT;
                        end
                        OP_LDI: state_d = ST_EXEC;
                        default: begin
                            ctrl_d  = op_in;
                            src0_d  = ra_data;
                            src1_d  = rb_data;
                            state_d = ST_EXEC;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                we = 1'b1;
                if (op_q != OP_LDI)
                    zero_d = (ula_result == '0);
                state_d = ST_IDLE;
            end
            ST_OUT: begin
                if (dout_ready)
                    state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            op_q    <= OP_INC0;
            rd_q    <= '0;
            imm_q   <= '0;
            ctrl_q  <= OP_INC0;
            src0_q  <= '0;
            src1_q  <= '0;
            dout_q  <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            imm_q   <= imm_d;
            ctrl_q  <= ctrl_d;
            src0_q  <= src0_d;
            src1_q  <= src1_d;
            dout_q  <= dout_d;
            zero_q  <= zero_d;
        end
    end

    assign instr_ready = (state_q == ST_IDLE);
    assign busy        = (state_q != ST_IDLE);
    assign dout_valid  = (state_q == ST_OUT);
    assign dout_data   = dout_q;
    assign ula_ctrl    = ctrl_q;
    assign ula_src0    = src0_q;
    assign ula_src1    = src1_q;
    assign zero        = zero_q;

endmodule
